// File: rtl/sha256_avs_pkg.sv
// sha256_avs_pkg: register map, bit indices, FSM states and IV shared by the SHA-256 Avalon agent
package sha256_avs_pkg;
   localparam logic [5:0] ADDR_MSG0   = 6'h00;
   localparam logic [5:0] ADDR_CTRL   = 6'h10;
   localparam logic [5:0] ADDR_STATUS = 6'h11;
   localparam int CTRL_START   = 0;
   localparam int CTRL_INIT    = 1;
   localparam int CTRL_IRQ_ENA = 2;
   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_ERR  = 2;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
   localparam logic [255:0] SHA256_IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] data,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? data[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction
endpackage

// File: rtl/sha256_avs_regfile.sv
// sha256_avs_regfile: 16-word message block store with byte-lane writes, flattened W0-first
module sha256_avs_regfile
   import sha256_avs_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [3:0]   idx,
   input  logic [31:0]  wdata,
   input  logic [3:0]   be,
   output logic [31:0]  rdata,
   output logic [511:0] block
);
   logic [31:0] msg [16];
   always_ff @(posedge clk)
      if (rst) for (int k = 0; k < 16; k++) msg[k] <= '0;
      else if (we) msg[idx] <= be_merge(msg[idx], wdata, be);
   assign rdata = msg[idx];
   for (genvar i = 0; i < 16; i++) begin : g_blk
      assign block[511-32*i -: 32] = msg[i];
   end
endmodule

// File: rtl/sha256_avs_agent.sv
// sha256_avs_agent: Avalon-MM responder fronting a SHA-256 compression core.
// Define SHA256_AVS_IRQ_EN to add the irq output and the CTRL.IRQ_ENA bit.
module sha256_avs_agent
   import sha256_avs_pkg::*;
#(
   parameter int                ADDR_W      = 6,
   parameter logic [ADDR_W-1:0] DIGEST_BASE = 6'h18
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic [3:0]        avs_byteenable,
   output logic [31:0]       avs_readdata,
   output logic              avs_readdatavalid,
   output logic              core_start,
   output logic              core_init,
   output logic [511:0]      core_block,
   input  logic              core_done,
   input  logic [255:0]      core_digest
`ifdef SHA256_AVS_IRQ_EN
   ,
   output logic              irq
`endif
);
   state_t state, state_nxt;
   logic init_q, done_q, err_q, irq_ena, busy;
   logic msg_sel, ctrl_wr, status_wr, dig_sel, start_req, start_ok, done_set, err_set, init_nxt, rd_req;
   logic [ADDR_W-1:0] dig_off;
   logic [31:0] msg_rdata, rd_data;
   logic [31:0] h [8];
   assign msg_sel   = avs_address < ADDR_W'(16);
   assign ctrl_wr   = avs_write && avs_address == ADDR_W'(ADDR_CTRL);
   assign status_wr = avs_write && avs_address == ADDR_W'(ADDR_STATUS) && avs_byteenable[0];
   assign start_req = ctrl_wr && avs_byteenable[0] && avs_writedata[CTRL_START];
   assign start_ok  = start_req && !busy;
   assign done_set  = state == WAIT && core_done;
   assign err_set   = busy && ((avs_write && msg_sel) || start_req);
   assign init_nxt  = ctrl_wr && avs_byteenable[0] ? avs_writedata[CTRL_INIT] : init_q;
   assign rd_req    = avs_read && !avs_write;
   assign dig_off   = avs_address - DIGEST_BASE;
   assign dig_sel   = dig_off < ADDR_W'(8);
   sha256_avs_regfile u_regfile (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .we    (avs_write && msg_sel && !busy),
      .idx   (avs_address[3:0]),
      .wdata (avs_writedata),
      .be    (avs_byteenable),
      .rdata (msg_rdata),
      .block (core_block)
   );
   always_ff @(posedge clk_clk)
      state <= reset_reset ? IDLE : state_nxt;
   always_comb begin
      state_nxt = IDLE;
      state_nxt = state == IDLE   ? (start_ok ? LAUNCH : IDLE) :
                  state == LAUNCH ? WAIT :
                  state == WAIT && !core_done ? WAIT : IDLE;
   end
   always_comb begin
      core_start = state == LAUNCH;
      busy       = state != IDLE;
   end
   // Sticky flags: a same-cycle set beats a software clear
   always_ff @(posedge clk_clk)
      if (reset_reset) begin
         init_q    <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         core_init <= 1'b1;
         for (int k = 0; k < 8; k++) h[k] <= '0;
      end else begin
         init_q <= init_nxt;
         done_q <= done_set || (done_q && !(status_wr && avs_writedata[ST_DONE]));
         err_q  <= err_set || (err_q && !(status_wr && avs_writedata[ST_ERR]));
         if (start_ok) core_init <= init_nxt;
         if (done_set) for (int k = 0; k < 8; k++) h[k] <= core_digest[255-32*k -: 32];
      end
   always_comb begin
      rd_data = '0;
      rd_data = msg_sel ? msg_rdata :
                avs_address == ADDR_W'(ADDR_CTRL)   ? {29'b0, irq_ena, init_q, 1'b0} :
                avs_address == ADDR_W'(ADDR_STATUS) ? {29'b0, err_q, done_q, busy} :
                dig_sel ? h[dig_off[2:0]] : '0;
   end
   always_ff @(posedge clk_clk)
      if (reset_reset) begin
         avs_readdatavalid <= 1'b0;
         avs_readdata      <= '0;
      end else begin
         avs_readdatavalid <= rd_req;
         if (rd_req) avs_readdata <= rd_data;
      end
`ifdef SHA256_AVS_IRQ_EN
   always_ff @(posedge clk_clk)
      if (reset_reset) begin
         irq_ena <= 1'b0;
         irq     <= 1'b0;
      end else begin
         if (ctrl_wr && avs_byteenable[0]) irq_ena <= avs_writedata[CTRL_IRQ_ENA];
         irq <= done_q && irq_ena;
      end
`else
   assign irq_ena = 1'b0;
`endif
endmodule

// File: tb/tb_sha256_avs_agent.sv
// tb_sha256_avs_agent: directed table plus multi-cycle sequences for the SHA-256 Avalon agent
module tb_sha256_avs_agent;
   import sha256_avs_pkg::*;
   localparam logic [255:0] ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [31:0] CTRL6 =
`ifdef SHA256_AVS_IRQ_EN
      32'h6;
`else
      32'h2;
`endif
   logic clk_clk = 0, reset_reset = 1, avs_read = 0, avs_write = 0;
   logic [5:0] avs_address = '0;
   logic [31:0] avs_writedata = '0, avs_readdata;
   logic [3:0] avs_byteenable = '0;
   logic avs_readdatavalid, core_start, core_init, core_done;
   logic [511:0] core_block;
   logic [255:0] core_digest = ABC;
   logic model_done = 0, man_done = 0;
   bit model_en = 1;
   int cnt = 0, starts = 0, n_vec = 0, n_fail = 0;
`ifdef SHA256_AVS_IRQ_EN
   logic irq;
`endif
   assign core_done = model_done | man_done;
   sha256_avs_agent dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset), .avs_address(avs_address),
      .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
      .avs_byteenable(avs_byteenable), .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid), .core_start(core_start), .core_init(core_init),
      .core_block(core_block), .core_done(core_done), .core_digest(core_digest)
`ifdef SHA256_AVS_IRQ_EN
      , .irq(irq)
`endif
   );
   always #5 clk_clk = ~clk_clk;
   // Core model: done pulse 10 cycles after a start pulse
   always @(negedge clk_clk) begin
      model_done = 0;
      if (cnt != 0) begin
         cnt--;
         if (cnt == 0) model_done = 1;
      end
      if (core_start) begin
         starts++;
         if (model_en) cnt = 10;
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask
   task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
      avs_address = a; avs_writedata = d; avs_byteenable = b; avs_write = 1;
      @(negedge clk_clk);
      avs_write = 0;
   endtask
   task automatic rd_chk(input string nm, input logic [5:0] a, input logic [31:0] exp);
      avs_address = a; avs_read = 1;
      @(negedge clk_clk);
      avs_read = 0;
      chk({nm, "_rdv"}, {31'b0, avs_readdatavalid}, 32'h1);
      chk(nm, avs_readdata, exp);
      @(negedge clk_clk);
      chk({nm, "_rdv_off"}, {31'b0, avs_readdatavalid}, 32'h0);
   endtask
   typedef struct {
      bit          w;
      logic [5:0]  a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [24];
   logic [31:0] ew [16];
   logic [31:0] d;
   initial begin
      tbl = '{
         '{0, 6'h10, 32'h0, 4'h0, 32'h2},        '{0, 6'h11, 32'h0, 4'h0, 32'h0},
         '{0, 6'h18, 32'h0, 4'h0, 32'h0},        '{0, 6'h00, 32'h0, 4'h0, 32'h0},
         '{1, 6'h01, 32'hAABBCCDD, 4'b0010, 0},  '{0, 6'h01, 32'h0, 4'h0, 32'h0000CC00},
         '{1, 6'h01, 32'h11223344, 4'b1001, 0},  '{0, 6'h01, 32'h0, 4'h0, 32'h1100CC44},
         '{1, 6'h10, 32'h0, 4'hF, 0},            '{0, 6'h10, 32'h0, 4'h0, 32'h0},
         '{1, 6'h10, 32'h6, 4'hE, 0},            '{0, 6'h10, 32'h0, 4'h0, 32'h0},
         '{1, 6'h10, 32'h6, 4'h1, 0},            '{0, 6'h10, 32'h0, 4'h0, CTRL6},
         '{1, 6'h20, 32'hDEAD, 4'hF, 0},         '{0, 6'h20, 32'h0, 4'h0, 32'h0},
         '{1, 6'h18, 32'h12345678, 4'hF, 0},     '{0, 6'h18, 32'h0, 4'h0, 32'h0},
         '{1, 6'h11, 32'h7, 4'hF, 0},            '{0, 6'h11, 32'h0, 4'h0, 32'h0},
         '{0, 6'h1F, 32'h0, 4'h0, 32'h0},        '{0, 6'h3F, 32'h0, 4'h0, 32'h0},
         '{1, 6'h10, 32'h2, 4'h1, 0},            '{0, 6'h10, 32'h0, 4'h0, 32'h2}
      };
      repeat (3) @(negedge clk_clk);
      reset_reset = 0;
      chk("rst_core_start", {31'b0, core_start}, 0);
      chk("rst_core_init", {31'b0, core_init}, 1);
      chk("rst_rdv", {31'b0, avs_readdatavalid}, 0);
      chk("rst_rdata", avs_readdata, 0);
      for (int i = 0; i < 24; i++)
         if (tbl[i].w) wr(tbl[i].a, tbl[i].d, tbl[i].be);
         else rd_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
      // read and write together: write lands, no read response
      avs_address = 6'h02; avs_writedata = 32'h55; avs_byteenable = 4'hF;
      avs_read = 1; avs_write = 1;
      @(negedge clk_clk);
      avs_read = 0; avs_write = 0;
      chk("rw_rdv", {31'b0, avs_readdatavalid}, 0);
      @(negedge clk_clk);
      chk("rw_rdv2", {31'b0, avs_readdatavalid}, 0);
      rd_chk("rw_w2", 6'h02, 32'h55);
      // padded "abc" block
      for (int i = 0; i < 16; i++) begin
         ew[i] = i == 0 ? 32'h61626380 : i == 15 ? 32'h18 : 32'h0;
         wr(6'(i), ew[i], 4'hF);
      end
      wr(ADDR_CTRL, 32'h3, 4'hF);
      chk("start_pulse", {31'b0, core_start}, 1);
      chk("start_init", {31'b0, core_init}, 1);
      @(negedge clk_clk);
      chk("start_single", {31'b0, core_start}, 0);
      rd_chk("busy", ADDR_STATUS, 32'h1);
      wr(6'h03, 32'hFFFFFFFF, 4'hF);
      wr(ADDR_CTRL, 32'h3, 4'hF);
      for (int i = 0; i < 16; i++) chk($sformatf("block_w%0d", i), core_block[511-32*i -: 32], ew[i]);
      rd_chk("w3_dropped", 6'h03, 32'h0);
      for (int k = 0; k < 40; k++) begin
         avs_address = ADDR_STATUS; avs_read = 1;
         @(negedge clk_clk);
         avs_read = 0; d = avs_readdata;
         @(negedge clk_clk);
         if (d[ST_DONE]) break;
      end
      chk("status_done_err", d, 32'h6);
      chk("start_count", starts, 1);
      rd_chk("h0", 6'h18, 32'hBA7816BF);
      rd_chk("h3", 6'h1B, 32'h5DAE2223);
      rd_chk("h7", 6'h1F, 32'hF20015AD);
      wr(ADDR_STATUS, 32'h6, 4'h1);
      rd_chk("w1c", ADDR_STATUS, 32'h0);
      // done in IDLE is ignored
      core_digest = SHA256_IV;
      man_done = 1;
      @(negedge clk_clk);
      man_done = 0;
      rd_chk("idle_done", ADDR_STATUS, 32'h0);
      rd_chk("idle_h0", 6'h18, 32'hBA7816BF);
      // reset while waiting
      model_en = 0;
      wr(ADDR_CTRL, 32'h1, 4'hF);
      chk("init0", {31'b0, core_init}, 0);
      repeat (2) @(negedge clk_clk);
      wr(ADDR_CTRL, 32'h2, 4'h1);
      chk("init_hold", {31'b0, core_init}, 0);
      rd_chk("init_reg", ADDR_CTRL, 32'h2);
      rd_chk("busy2", ADDR_STATUS, 32'h1);
      reset_reset = 1;
      @(negedge clk_clk);
      reset_reset = 0; man_done = 1;
      @(negedge clk_clk);
      man_done = 0;
      rd_chk("rst_status", ADDR_STATUS, 32'h0);
      rd_chk("rst_h0", 6'h18, 32'h0);
      chk("rst_init", {31'b0, core_init}, 1);
      // set beats same-cycle W1C
      wr(ADDR_CTRL, 32'h3, 4'hF);
      @(negedge clk_clk);
      man_done = 1;
      @(negedge clk_clk);
      man_done = 0;
      rd_chk("done1", ADDR_STATUS, 32'h2);
      wr(ADDR_CTRL, 32'h3, 4'hF);
      @(negedge clk_clk);
      avs_address = ADDR_STATUS; avs_writedata = 32'h2; avs_byteenable = 4'h1;
      avs_write = 1; man_done = 1;
      @(negedge clk_clk);
      avs_write = 0; man_done = 0;
      rd_chk("set_wins", ADDR_STATUS, 32'h2);
      rd_chk("iv_h0", 6'h18, 32'h6A09E667);
`ifdef SHA256_AVS_IRQ_EN
      wr(ADDR_CTRL, 32'h4, 4'h1);
      @(negedge clk_clk);
      chk("irq_on", {31'b0, irq}, 1);
      wr(ADDR_STATUS, 32'h2, 4'h1);
      @(negedge clk_clk);
      chk("irq_off", {31'b0, irq}, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
